// File: rtl/counter_sequencer.sv
// Run-control FSM plus prescaled up-counter: counts 0..limit, pulses done, supports pause/abort.
// Optional AUTO_RELOAD_EN: completed runs restart automatically until aborted.
module counter_sequencer #(
    parameter int WIDTH    = 5,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             busy_q, paused_q, done_q;
    logic [WIDTH-1:0] count_inc;
    logic             tick;

    assign count_inc = count_q + 1'b1;
    assign tick      = (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lim_d   = lim_q;
        presc_d = presc_q;
        case (state_q)
            IDLE: begin
                if (abort) begin
                    count_d = '0;
                end else if (start) begin
                    lim_d   = limit;
                    count_d = '0;
                    presc_d = '0;
                    state_d = (limit == '0) ? DONE : RUN;
                end
            end
            RUN, HOLD: begin
                if (abort) begin
                    count_d = '0;
                    presc_d = '0;
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = HOLD;
                end else if (lim_q == '0) begin
                    // only reachable when a zero-length run is reloaded
                    state_d = DONE;
                end else begin
                    // leaving HOLD counts on the same edge so pause costs exactly its own cycles
                    state_d = RUN;
                    if (tick) begin
                        presc_d = '0;
                        count_d = count_inc;
                        if (count_inc == lim_q) state_d = DONE;
                    end else begin
                        presc_d = PW'(presc_q + 1'b1);
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    count_d = '0;
                    state_d = IDLE;
                end else begin
`ifdef AUTO_RELOAD_EN
                    count_d = '0;
                    presc_d = '0;
                    state_d = RUN;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            lim_q    <= '0;
            presc_q  <= '0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            lim_q    <= lim_d;
            presc_q  <= presc_d;
            busy_q   <= (state_d == RUN) || (state_d == HOLD);
            paused_q <= (state_d == HOLD);
            done_q   <= (state_d == DONE);
        end
    end

    assign count  = count_q;
    assign busy   = busy_q;
    assign paused = paused_q;
    assign done   = done_q;
endmodule
